dmem_responder: RTL

Data-memory responder on the far side of the MEM-stage load/store interface. It accepts one load or store request from the MEM stage, inserts a configurable number of wait states, and performs byte-lane steering and sign/zero extension. It returns the load result with a one-cycle response strobe and drives the MEM-stage stall while an access is outstanding. It contains a word-organised, little-endian synchronous data array.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: accepts one request,
// waits WAIT_STATES cycles, then performs the lane-steered access and returns a one-cycle response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_sz,
    input  logic        req_sx,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  sz_q;
    logic        sx_q, we_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          access, err, wr_en;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd, rword, ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        stall     = 1'b0;
        req_ready = (state == S_IDLE);
        case (state)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        idx   = addr_q[AW+1:2];
        rword = mem[idx];
        err   = (sz_q == 2'd3)
              | ((sz_q == 2'd1) & addr_q[0])
              | ((sz_q == 2'd2) & (addr_q[1:0] != 2'b00))
              | (addr_q >= LIMIT);

        ld_byte = 8'(rword >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? rword[31:16] : rword[15:0];
        case (sz_q)
            2'd0:    ld_data = {{24{sx_q & ld_byte[7]}}, ld_byte};
            2'd1:    ld_data = {{16{sx_q & ld_half[15]}}, ld_half};
            default: ld_data = rword;
        endcase

        // Sub-word store data is replicated across lanes so the byte enables alone select placement.
        case (sz_q)
            2'd0: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
        wr_en = access & we_q & ~err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sz_q      <= '0;
            sx_q      <= 1'b0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= access;
            if (state == S_IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                sz_q    <= req_sz;
                sx_q    <= req_sx;
                we_q    <= req_we;
            end
            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (err || we_q) ? '0 : ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end
endmodule
